// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port indices
// and the width of the starvation counter.
package dm_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // Wide enough for MAX_WAIT up to 15.
  localparam int WAIT_W = 4;

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of both requester ports plus the datamemory-side signals.
// The arbiter uses the slave view; requesters and memory use the master view.
interface dm_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic              p1_req;
  logic              p0_we;
  logic              p1_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [DATA_W-1:0] p1_wdata;
  logic              p0_gnt;
  logic              p1_gnt;
  logic              p0_rvalid;
  logic              p1_rvalid;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_we;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata, mem_dout,
    output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rdata, mem_addr, mem_din, mem_we
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata, mem_dout,
    input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rdata, mem_addr, mem_din, mem_we
  );
endinterface

// File: rtl/dm_arbiter_arb_pick.sv
// Winner selection for the two ports: fixed priority with a starvation escape
// for port 1, or round-robin. Owns the last_owner and wait_cnt history.
module arb_pick
  import dm_arbiter_pkg::*;
#(
  parameter int RR_MODE  = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       winner_o
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  logic              last_owner_q, last_owner_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    winner_o     = PORT_CPU;
    last_owner_d = last_owner_q;
    wait_cnt_d   = wait_cnt_q;

    if (req_i[1] && !req_i[0]) begin
      winner_o = PORT_DBG;
    end else if (&req_i) begin
      winner_o = (RR_MODE != 0) ? ~last_owner_q : (wait_cnt_q == MAX_WAIT_C);
    end

    // History only moves when a grant is actually issued.
    if (accept_i && (|req_i)) begin
      last_owner_d = winner_o;
      if (winner_o == PORT_DBG) begin
        wait_cnt_d = '0;
      end else if (req_i[1] && (wait_cnt_q != MAX_WAIT_C)) begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_owner_q <= PORT_DBG;
      wait_cnt_q   <= '0;
    end else begin
      last_owner_q <= last_owner_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the data memory: grant, one registered access
// cycle, then a one-cycle response carrying the captured memory output.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RR_MODE  = 0,
  parameter int MAX_WAIT = 4
) (
  input logic        clk,
  input logic        reset_n,
  dm_arbiter_if.slave bus
);

  state_e            state_q;
  logic              owner_q;
  logic [1:0]        rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q;
  logic              mem_we_q;

  logic [1:0] req;
  logic       accept;
  logic       winner;

  assign req    = {bus.p1_req, bus.p0_req};
  assign accept = (state_q != ST_ACCESS) && (|req);

  arb_pick #(
    .RR_MODE  (RR_MODE),
    .MAX_WAIT (MAX_WAIT)
  ) u_pick (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_i    (req),
    .accept_i (accept),
    .winner_o (winner)
  );

  // Grants are masked while reset is held so every output reads 0 immediately.
  assign bus.p0_gnt    = reset_n && accept && (winner == PORT_CPU);
  assign bus.p1_gnt    = reset_n && accept && (winner == PORT_DBG);
  assign bus.p0_rvalid = rvalid_q[0];
  assign bus.p1_rvalid = rvalid_q[1];
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.mem_we    = mem_we_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= PORT_CPU;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCESS: begin
          rdata_q  <= bus.mem_dout;
          rvalid_q <= (owner_q == PORT_DBG) ? 2'b10 : 2'b01;
          mem_we_q <= 1'b0;
          state_q  <= ST_RESP;
        end
        default: begin
          rvalid_q <= '0;
          if (accept) begin
            owner_q    <= winner;
            mem_addr_q <= (winner == PORT_DBG) ? bus.p1_addr : bus.p0_addr;
            mem_din_q  <= (winner == PORT_DBG) ? bus.p1_wdata : bus.p0_wdata;
            mem_we_q   <= (winner == PORT_DBG) ? bus.p1_we : bus.p0_we;
            state_q    <= ST_ACCESS;
          end else begin
            state_q    <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Runs a fixed-priority and a round-robin arbiter side by side against a
// cycle-count reference model; a monitor process checks every response.
module tb_dm_arbiter;

  localparam int MW = 4;

  typedef struct {
    int          inst;
    int          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n_v;
  logic [1:0]  req_v     [2];
  logic [1:0]  we_v      [2];
  logic [31:0] addr_v    [2][2];
  logic [31:0] wdata_v   [2][2];
  logic [1:0]  gnt_v     [2];
  logic [1:0]  rvalid_v  [2];
  logic [31:0] rdata_v   [2];
  logic [31:0] mem_addr_v[2];
  logic [31:0] mem_din_v [2];
  logic        mem_we_v  [2];

  int n_checks;
  int n_pass;
  int cyc;
  int gen_mode;

  logic [1:0]  pend   [2];
  logic [1:0]  pwe    [2];
  logic [31:0] paddr  [2][2];
  logic [31:0] pwdata [2][2];
  logic [31:0] ref_mem[2][256];
  int          last_owner[2];
  int          wait_cnt[2];
  int          next_free[2];
  exp_t        exp_q[$];
  int          glog0[$];
  int          glog1[$];

  function automatic logic [31:0] init_word(int k, int a);
    if (a == 16) return 32'hDEADBEEF;
    return 32'h5A000000 ^ (32'(k) << 20) ^ (32'(a) * 32'h00010101);
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    dm_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    logic [31:0] mem [256];

    assign bus.p0_req   = req_v[gi][0];
    assign bus.p1_req   = req_v[gi][1];
    assign bus.p0_we    = we_v[gi][0];
    assign bus.p1_we    = we_v[gi][1];
    assign bus.p0_addr  = addr_v[gi][0];
    assign bus.p1_addr  = addr_v[gi][1];
    assign bus.p0_wdata = wdata_v[gi][0];
    assign bus.p1_wdata = wdata_v[gi][1];
    assign bus.mem_dout = mem[bus.mem_addr[7:0]];

    assign gnt_v[gi]      = {bus.p1_gnt, bus.p0_gnt};
    assign rvalid_v[gi]   = {bus.p1_rvalid, bus.p0_rvalid};
    assign rdata_v[gi]    = bus.rdata;
    assign mem_addr_v[gi] = bus.mem_addr;
    assign mem_din_v[gi]  = bus.mem_din;
    assign mem_we_v[gi]   = bus.mem_we;

    initial for (int a = 0; a < 256; a++) mem[a] = init_word(gi, a);
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_din;

    dm_arbiter #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .RR_MODE  (gi),
      .MAX_WAIT (MW)
    ) dut (
      .clk     (clk),
      .reset_n (rst_n_v[gi]),
      .bus     (bus)
    );
  end

  task automatic chk(int k, string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d cyc%0d: got %08h expected %08h", name, k, cyc, act, exp);
  endtask

  // Arbitration rules applied to the requests pending at a grant opportunity.
  function automatic int model_pick(int k);
    bit r0 = pend[k][0];
    bit r1 = pend[k][1];
    int w;
    if (r0 && r1) w = (k == 1) ? 1 - last_owner[k] : ((wait_cnt[k] == MW) ? 1 : 0);
    else          w = r1 ? 1 : 0;
    last_owner[k] = w;
    if (w == 1) wait_cnt[k] = 0;
    else if (r1 && wait_cnt[k] < MW) wait_cnt[k]++;
    return w;
  endfunction

  task automatic step();
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[k][p] && rst_n_v[k] &&
            (gen_mode == 1 || (gen_mode == 2 && $urandom_range(0, 99) < 40))) begin
          pend[k][p]   = 1'b1;
          pwe[k][p]    = 1'($urandom_range(0, 1));
          paddr[k][p]  = 32'($urandom_range(0, 255));
          pwdata[k][p] = $urandom;
        end
        req_v[k][p]   = pend[k][p];
        we_v[k][p]    = pwe[k][p];
        addr_v[k][p]  = paddr[k][p];
        wdata_v[k][p] = pwdata[k][p];
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      logic [1:0] expg;
      int w;
      exp_t e;
      expg = 2'b00;
      w = 0;
      if (rst_n_v[k] && cyc >= next_free[k] && (pend[k] != 2'b00)) begin
        w = model_pick(k);
        expg = (w == 1) ? 2'b10 : 2'b01;
      end
      chk(k, "gnt", 32'(gnt_v[k]), 32'(expg));
      if (gnt_v[k] == 2'b01 || gnt_v[k] == 2'b10) begin
        if (k == 0) glog0.push_back(gnt_v[k] == 2'b10 ? 1 : 0);
        else        glog1.push_back(gnt_v[k] == 2'b10 ? 1 : 0);
      end
      if (expg != 2'b00) begin
        e.inst  = k;
        e.port  = w;
        e.we    = pwe[k][w];
        e.addr  = paddr[k][w];
        e.wdata = pwdata[k][w];
        e.rdata = ref_mem[k][paddr[k][w][7:0]];
        e.cyc   = cyc + 2;
        exp_q.push_back(e);
        if (pwe[k][w]) ref_mem[k][paddr[k][w][7:0]] = pwdata[k][w];
        pend[k][w]   = 1'b0;
        next_free[k] = cyc + 2;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((pend[0] != 2'b00 || pend[1] != 2'b00 || exp_q.size() != 0) && n < 100) begin
      step();
      n++;
    end
    chk(0, "drain_budget", 32'(n < 100), 32'd1);
  endtask

  task automatic issue(int p, bit we, logic [31:0] a, logic [31:0] d);
    for (int k = 0; k < 2; k++) begin
      pend[k][p]   = 1'b1;
      pwe[k][p]    = we;
      paddr[k][p]  = a;
      pwdata[k][p] = d;
    end
  endtask

  task automatic apply_reset();
    rst_n_v = 2'b00;
    for (int k = 0; k < 2; k++) begin
      pend[k]       = 2'b00;
      last_owner[k] = 1;
      wait_cnt[k]   = 0;
      next_free[k]  = 0;
    end
    exp_q.delete();
  endtask

  task automatic release_reset();
    for (int k = 0; k < 2; k++) req_v[k] = 2'b00;
    rst_n_v = 2'b11;
  endtask

  // Monitor: compares memory-side activity and responses with the scoreboard.
  always @(negedge clk) begin
    #2;
    for (int k = 0; k < 2; k++) begin
      int idx;
      logic [1:0] erv;
      logic ewe;
      if (rst_n_v[k]) begin
        idx = -1;
        erv = 2'b00;
        ewe = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (exp_q[i].inst == k) begin
            idx = i;
            break;
          end
        end
        if (idx >= 0 && exp_q[idx].cyc - 1 == cyc) begin
          ewe = exp_q[idx].we;
          chk(k, "mem_addr", mem_addr_v[k], exp_q[idx].addr);
          if (ewe) chk(k, "mem_din", mem_din_v[k], exp_q[idx].wdata);
        end
        chk(k, "mem_we", 32'(mem_we_v[k]), 32'(ewe));
        if (idx >= 0 && exp_q[idx].cyc == cyc) erv = (exp_q[idx].port == 1) ? 2'b10 : 2'b01;
        chk(k, "rvalid", 32'(rvalid_v[k]), 32'(erv));
        if (erv != 2'b00) begin
          chk(k, "rdata", rdata_v[k], exp_q[idx].rdata);
          $display("inst%0d cyc%0d port%0d %s addr %02h wdata %08h rdata %08h",
                   k, cyc, exp_q[idx].port, exp_q[idx].we ? "WR" : "RD",
                   exp_q[idx].addr[7:0], exp_q[idx].wdata, rdata_v[k]);
        end
        if (idx >= 0 && exp_q[idx].cyc <= cyc) exp_q.delete(idx);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    gen_mode = 0;
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 256; a++) ref_mem[k][a] = init_word(k, a);
      req_v[k] = 2'b00;
      we_v[k]  = 2'b00;
      pwe[k]   = 2'b00;
      for (int p = 0; p < 2; p++) begin
        addr_v[k][p]  = '0;
        wdata_v[k][p] = '0;
        paddr[k][p]   = '0;
        pwdata[k][p]  = '0;
      end
    end
    apply_reset();
    repeat (3) step();
    release_reset();

    repeat (3) step();
    for (int k = 0; k < 2; k++) begin
      chk(k, "idle_rdata", rdata_v[k], 32'h0);
      chk(k, "idle_mem_addr", mem_addr_v[k], 32'h0);
    end

    issue(0, 1'b0, 32'h10, 32'h0);
    drain();
    issue(1, 1'b1, 32'h20, 32'h1234);
    drain();
    issue(0, 1'b0, 32'h20, 32'h0);
    drain();

    // Asynchronous reset mid-cycle with both requests raised.
    @(negedge clk);
    for (int k = 0; k < 2; k++) req_v[k] = 2'b11;
    #3;
    apply_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk(k, "rst_gnt", 32'(gnt_v[k]), 32'h0);
      chk(k, "rst_rvalid", 32'(rvalid_v[k]), 32'h0);
      chk(k, "rst_rdata", rdata_v[k], 32'h0);
      chk(k, "rst_mem_addr", mem_addr_v[k], 32'h0);
      chk(k, "rst_mem_din", mem_din_v[k], 32'h0);
      chk(k, "rst_mem_we", 32'(mem_we_v[k]), 32'h0);
    end
    repeat (2) @(negedge clk);
    release_reset();

    glog0.delete();
    glog1.delete();
    gen_mode = 1;
    repeat (24) step();
    gen_mode = 0;
    drain();
    chk(0, "contention_grants", 32'(glog0.size() >= 10), 32'd1);
    chk(1, "contention_grants", 32'(glog1.size() >= 10), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i < glog0.size()) chk(0, "starve_pattern", 32'(glog0[i]), 32'((i % 5) == 4));
      if (i < glog1.size()) chk(1, "rr_pattern", 32'(glog1[i]), 32'(i % 2));
    end

    gen_mode = 2;
    repeat (300) step();
    gen_mode = 0;
    drain();

    // Reset while a write is on the memory bus.
    issue(1, 1'b1, 32'h30, 32'h77);
    step();
    @(posedge clk);
    #2;
    for (int k = 0; k < 2; k++) begin
      chk(k, "access_mem_we", 32'(mem_we_v[k]), 32'd1);
      chk(k, "access_mem_din", mem_din_v[k], 32'h77);
    end
    apply_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk(k, "rst_access_mem_we", 32'(mem_we_v[k]), 32'h0);
      chk(k, "rst_access_rvalid", 32'(rvalid_v[k]), 32'h0);
      req_v[k] = 2'b00;
    end
    repeat (2) @(negedge clk);
    release_reset();
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
